// File: rtl/ccff_loader_pkg.sv
// Shared types and sizing helpers for the grid_ccff_frame_loader block.
// Optional parity checking on the beat interface is enabled by defining CCFF_PARITY_EN.
package ccff_loader_pkg;

  localparam int DEF_NUM_CHAINS = 4;
  localparam int DEF_CHAIN_LEN  = 32;
  localparam int CFG_W          = DEF_NUM_CHAINS * DEF_CHAIN_LEN;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT,
    ST_RB_LOAD,
    ST_READBACK
  } ccff_state_e;

  function automatic int cnt_width(input int chain_len);
    return $clog2(chain_len);
  endfunction

endpackage

// File: rtl/ccff_shift_chain.sv
// One shadow configuration chain: parallel load has priority over a
// left shift that brings the new bit in at the LSB.
module ccff_shift_chain
  import ccff_loader_pkg::*;
#(
  parameter int LEN = DEF_CHAIN_LEN
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           shift_en,
  input  logic           shift_in,
  input  logic           load_en,
  input  logic [LEN-1:0] load_data,
  output logic           msb,
  output logic [LEN-1:0] data
);

  logic [LEN-1:0] data_q;
  logic [LEN-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_en) begin
      data_d = load_data;
    end else if (shift_en) begin
      data_d = {data_q[LEN-2:0], shift_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign msb  = data_q[LEN-1];
  assign data = data_q;

endmodule

// File: rtl/grid_ccff_frame_loader.sv
// Loads NUM_CHAINS parallel config chains through a valid/ready beat port, commits
// them atomically, and supports test-mode readback. Optional parity: CCFF_PARITY_EN.
module grid_ccff_frame_loader
  import ccff_loader_pkg::*;
#(
  parameter int NUM_CHAINS = DEF_NUM_CHAINS,
  parameter int CHAIN_LEN  = DEF_CHAIN_LEN
) (
  input  logic                            prog_clk,
  input  logic                            pReset_n,
  input  logic                            config_enable,
  input  logic                            Test_en,
  input  logic                            rb_start,
  input  logic [NUM_CHAINS-1:0]           ccff_head,
  input  logic                            ccff_valid,
`ifdef CCFF_PARITY_EN
  input  logic                            ccff_parity,
  output logic                            parity_err,
`endif
  output logic                            ccff_ready,
  output logic [NUM_CHAINS-1:0]           ccff_tail,
  output logic [NUM_CHAINS*CHAIN_LEN-1:0] cfg_bits,
  output logic                            config_done,
  output logic                            cfg_abort
);

  localparam int TOTAL_W = NUM_CHAINS * CHAIN_LEN;
  localparam int CNT_W   = cnt_width(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  // Beat handshake: a beat transfers on a rising prog_clk edge where
  // ccff_valid and ccff_ready are both high; ready only rises in SHIFT.

  ccff_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TOTAL_W-1:0] cfg_q, cfg_d;
  logic               done_q, done_d;
  logic               abort_q, abort_d;
  logic [TOTAL_W-1:0] shadow;
  logic               shift_en;
  logic               load_en;
  logic               ready;
  logic               frame_bad;

`ifdef CCFF_PARITY_EN
  logic frame_err_q, frame_err_d;
  logic parity_err_q, parity_err_d;
  logic beat_bad;

  assign beat_bad  = (^ccff_head) != ccff_parity;
  assign frame_bad = frame_err_q | beat_bad;
`else
  assign frame_bad = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cfg_d    = cfg_q;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    shift_en = 1'b0;
    load_en  = 1'b0;
    ready    = 1'b0;
`ifdef CCFF_PARITY_EN
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (config_enable) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
`ifdef CCFF_PARITY_EN
          frame_err_d = 1'b0;
`endif
        end else if (rb_start && Test_en) begin
          state_d = ST_RB_LOAD;
        end
      end
      ST_SHIFT: begin
        ready = config_enable;
        if (!config_enable) begin
          // Dropping the window mid-frame abandons it; shadow keeps partial data.
          state_d = ST_IDLE;
          cnt_d   = '0;
          abort_d = (cnt_q != '0);
`ifdef CCFF_PARITY_EN
          frame_err_d = 1'b0;
`endif
        end else if (ccff_valid) begin
          shift_en = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (frame_bad) begin
              state_d = ST_IDLE;
`ifdef CCFF_PARITY_EN
              parity_err_d = 1'b1;
              frame_err_d  = 1'b0;
`endif
            end else begin
              state_d = ST_COMMIT;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
`ifdef CCFF_PARITY_EN
            frame_err_d = frame_bad;
`endif
          end
        end
      end
      ST_COMMIT: begin
        cfg_d = shadow;
`ifdef CCFF_PARITY_EN
        parity_err_d = 1'b0;
`endif
        if (config_enable) begin
          state_d = ST_SHIFT;
`ifdef CCFF_PARITY_EN
          frame_err_d = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RB_LOAD: begin
        load_en = 1'b1;
        cnt_d   = '0;
        state_d = Test_en ? ST_READBACK : ST_IDLE;
      end
      ST_READBACK: begin
        if (!Test_en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          shift_en = 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cfg_q   <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

`ifdef CCFF_PARITY_EN
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`endif

  for (genvar c = 0; c < NUM_CHAINS; c++) begin : g_chain
    ccff_shift_chain #(
      .LEN(CHAIN_LEN)
    ) u_chain (
      .clk      (prog_clk),
      .rst_n    (pReset_n),
      .shift_en (shift_en),
      .shift_in (ccff_head[c]),
      .load_en  (load_en),
      .load_data(cfg_q[c*CHAIN_LEN +: CHAIN_LEN]),
      .msb      (ccff_tail[c]),
      .data     (shadow[c*CHAIN_LEN +: CHAIN_LEN])
    );
  end

  assign ccff_ready  = ready;
  assign cfg_bits    = cfg_q;
  assign config_done = done_q;
  assign cfg_abort   = abort_q;

endmodule

// File: tb/tb_grid_ccff_frame_loader.sv
// Bench for grid_ccff_frame_loader (NUM_CHAINS=2, CHAIN_LEN=4); define CCFF_PARITY_EN
// to also exercise the parity path.
module tb_grid_ccff_frame_loader;
  import ccff_loader_pkg::*;

  localparam int NC  = 2;
  localparam int CL  = 4;
  localparam int CFG = NC * CL;

  logic           prog_clk;
  logic           pReset_n;
  logic           config_enable;
  logic           Test_en;
  logic           rb_start;
  logic [NC-1:0]  ccff_head;
  logic           ccff_valid;
  logic           ccff_ready;
  logic [NC-1:0]  ccff_tail;
  logic [CFG-1:0] cfg_bits;
  logic           config_done;
  logic           cfg_abort;
`ifdef CCFF_PARITY_EN
  logic           ccff_parity;
  logic           parity_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [CFG-1:0] model_cfg;

  grid_ccff_frame_loader #(
    .NUM_CHAINS(NC),
    .CHAIN_LEN (CL)
  ) dut (
    .prog_clk     (prog_clk),
    .pReset_n     (pReset_n),
    .config_enable(config_enable),
    .Test_en      (Test_en),
    .rb_start     (rb_start),
    .ccff_head    (ccff_head),
    .ccff_valid   (ccff_valid),
`ifdef CCFF_PARITY_EN
    .ccff_parity  (ccff_parity),
    .parity_err   (parity_err),
`endif
    .ccff_ready   (ccff_ready),
    .ccff_tail    (ccff_tail),
    .cfg_bits     (cfg_bits),
    .config_done  (config_done),
    .cfg_abort    (cfg_abort)
  );

  // clock / reset
  initial begin
    prog_clk = 1'b0;
    forever #5 prog_clk = ~prog_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  // Reference model: the first beat of a frame ends up as the chain MSB.
  function automatic logic [CFG-1:0] assemble(input logic [CFG-1:0] beats);
    logic [CFG-1:0] r;
    r = '0;
    for (int i = 0; i < CL; i++)
      for (int c = 0; c < NC; c++)
        r[c*CL + (CL-1-i)] = beats[i*NC + c];
    return r;
  endfunction

  function automatic logic [CFG-1:0] beats_for(input logic [CFG-1:0] cfg);
    logic [CFG-1:0] b;
    b = '0;
    for (int i = 0; i < CL; i++)
      for (int c = 0; c < NC; c++)
        b[i*NC + c] = cfg[c*CL + (CL-1-i)];
    return b;
  endfunction

  // Drives nbeats beats (beat i in beats[i*NC +: NC]) with gap idle cycles between.
  task automatic send_frame(input logic [CFG-1:0] beats, input int nbeats,
                            input int gap, input int bad_beat);
    int w;
    for (int i = 0; i < nbeats; i++) begin
      ccff_head = beats[i*NC +: NC];
`ifdef CCFF_PARITY_EN
      ccff_parity = (^ccff_head) ^ (i == bad_beat);
`endif
      ccff_valid = 1'b1;
      w = 0;
      while (ccff_ready !== 1'b1 && w < 20) begin
        tick();
        w++;
      end
      if (w == 20) begin
        n_checks++;
        n_fail++;
        $display("FAIL ready_timeout beat %0d: ready=%b required 1", i, ccff_ready);
      end
      tick();
      ccff_valid = 1'b0;
      if (i < CL-1) begin
        n_checks++;
        if (config_done !== 1'b0) begin
          n_fail++;
          $display("FAIL done_early beat %0d: config_done=%b required 0", i, config_done);
        end
      end
      if (i < nbeats-1) repeat (gap) tick();
    end
  endtask

  task automatic test_reset();
    pReset_n = 1'b1; config_enable = 1'b0; Test_en = 1'b0; rb_start = 1'b0;
    ccff_head = '0; ccff_valid = 1'b0;
`ifdef CCFF_PARITY_EN
    ccff_parity = 1'b0;
`endif
    #2 pReset_n = 1'b0;
    #1;
    n_checks++; if (cfg_bits !== '0) begin n_fail++; $display("FAIL rst_cfg: got %h required 0", cfg_bits); end
    n_checks++; if (ccff_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b required 0", ccff_ready); end
    n_checks++; if (ccff_tail !== '0) begin n_fail++; $display("FAIL rst_tail: got %b required 0", ccff_tail); end
    n_checks++; if (config_done !== 1'b0 || cfg_abort !== 1'b0) begin
      n_fail++; $display("FAIL rst_pulses: done=%b abort=%b required 0 0", config_done, cfg_abort); end
`ifdef CCFF_PARITY_EN
    n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL rst_perr: got %b required 0", parity_err); end
`endif
    repeat (2) tick();
    pReset_n = 1'b1;
    tick();
    n_checks++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d required IDLE", dut.state_q); end
    n_checks++; if (ccff_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_idle: got %b required 0", ccff_ready); end
    model_cfg = '0;
  endtask

  // beats 11,00,10,01 -> cfg 8'hA9
  task automatic test_load(input int gap, input string tag);
    config_enable = 1'b1;
    send_frame(8'h63, CL, gap, -1);
    n_checks++; if (config_done !== 1'b1) begin n_fail++; $display("FAIL %s_done: got %b required 1", tag, config_done); end
    model_cfg = assemble(8'h63);
    tick();
    n_checks++; if (config_done !== 1'b0) begin n_fail++; $display("FAIL %s_done_pulse: got %b required 0", tag, config_done); end
    n_checks++; if (cfg_bits !== 8'hA9) begin n_fail++; $display("FAIL %s_cfg: got %h required a9", tag, cfg_bits); end
    n_checks++; if (cfg_bits !== model_cfg) begin n_fail++; $display("FAIL %s_model: got %h required %h", tag, cfg_bits, model_cfg); end
  endtask

  task automatic test_abort();
    config_enable = 1'b1;
    send_frame(8'hFF, 2, 0, -1);
    config_enable = 1'b0;
    tick();
    n_checks++; if (cfg_abort !== 1'b1 || config_done !== 1'b0) begin
      n_fail++; $display("FAIL abort_pulse: abort=%b done=%b required 1 0", cfg_abort, config_done); end
    tick();
    n_checks++; if (cfg_abort !== 1'b0) begin n_fail++; $display("FAIL abort_width: got %b required 0", cfg_abort); end
    n_checks++; if (cfg_bits !== model_cfg) begin n_fail++; $display("FAIL abort_cfg: got %h required %h", cfg_bits, model_cfg); end
    // config_enable wins over a simultaneous readback request; a drop at count 0 is silent
    config_enable = 1'b1; Test_en = 1'b1; rb_start = 1'b1;
    tick();
    rb_start = 1'b0; Test_en = 1'b0;
    n_checks++; if (ccff_ready !== 1'b1) begin n_fail++; $display("FAIL enable_priority: ready=%b required 1", ccff_ready); end
    config_enable = 1'b0;
    tick();
    tick();
    n_checks++; if (cfg_abort !== 1'b0) begin n_fail++; $display("FAIL silent_abort: got %b required 0", cfg_abort); end
    config_enable = 1'b1;
    send_frame(8'h00, CL, 0, -1);
    n_checks++; if (config_done !== 1'b1) begin n_fail++; $display("FAIL abort_reload_done: got %b required 1", config_done); end
    model_cfg = assemble(8'h00);
    config_enable = 1'b0;
    tick();
    n_checks++; if (cfg_bits !== 8'h00) begin n_fail++; $display("FAIL abort_reload_cfg: got %h required 00", cfg_bits); end
  endtask

  task automatic test_readback(input int drop_at);
    logic [CL-1:0] chain;
    config_enable = 1'b0;
    tick();
    Test_en = 1'b1; rb_start = 1'b1;
    tick();
    rb_start = 1'b0;
    tick();
    for (int k = 0; k < CL; k++) begin
      for (int c = 0; c < NC; c++) begin
        chain = model_cfg[c*CL +: CL];
        n_checks++;
        if (ccff_tail[c] !== chain[CL-1-k]) begin
          n_fail++; $display("FAIL rb_tail c%0d k%0d: got %b required %b", c, k, ccff_tail[c], chain[CL-1-k]);
        end
      end
      n_checks++; if (config_done !== 1'b0 || ccff_ready !== 1'b0) begin
        n_fail++; $display("FAIL rb_ctrl k%0d: done=%b ready=%b required 0 0", k, config_done, ccff_ready); end
      if (k == drop_at) begin
        Test_en = 1'b0;
        repeat (2) tick();
        for (int c = 0; c < NC; c++) begin
          chain = model_cfg[c*CL +: CL];
          n_checks++;
          if (ccff_tail[c] !== chain[CL-1-k]) begin
            n_fail++; $display("FAIL rb_drop_hold c%0d: got %b required %b", c, ccff_tail[c], chain[CL-1-k]);
          end
        end
        break;
      end
      ccff_head = NC'($urandom);
      tick();
    end
    Test_en = 1'b0;
    n_checks++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL rb_end_state: got %0d required IDLE", dut.state_q); end
    n_checks++; if (cfg_bits !== model_cfg) begin n_fail++; $display("FAIL rb_cfg: got %h required %h", cfg_bits, model_cfg); end
  endtask

  task automatic test_random();
    logic [CFG-1:0] val;
    int gap;
    int nb;
    for (int it = 0; it < 10; it++) begin
      val = CFG'($urandom);
      gap = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) begin
        nb = $urandom_range(1, CL-1);
        config_enable = 1'b1;
        send_frame(CFG'($urandom), nb, gap, -1);
        config_enable = 1'b0;
        tick();
        n_checks++; if (cfg_abort !== 1'b1) begin n_fail++; $display("FAIL rnd_abort it%0d: got %b required 1", it, cfg_abort); end
        n_checks++; if (cfg_bits !== model_cfg) begin n_fail++; $display("FAIL rnd_abort_cfg it%0d: got %h required %h", it, cfg_bits, model_cfg); end
      end
      config_enable = 1'b1;
      send_frame(beats_for(val), CL, gap, -1);
      n_checks++; if (config_done !== 1'b1) begin n_fail++; $display("FAIL rnd_done it%0d: got %b required 1", it, config_done); end
      model_cfg = val;
      config_enable = 1'($urandom_range(0, 1));
      tick();
      n_checks++; if (cfg_bits !== model_cfg) begin n_fail++; $display("FAIL rnd_cfg it%0d: got %h required %h", it, cfg_bits, model_cfg); end
      if (it % 3 == 2) test_readback($urandom_range(0, CL));
    end
    config_enable = 1'b0;
    tick();
  endtask

`ifdef CCFF_PARITY_EN
  task automatic test_parity();
    logic [CFG-1:0] val;
    config_enable = 1'b1;
    send_frame(8'h63, CL, 0, 2);
    n_checks++; if (config_done !== 1'b0) begin n_fail++; $display("FAIL par_done: got %b required 0", config_done); end
    n_checks++; if (parity_err !== 1'b1) begin n_fail++; $display("FAIL par_err: got %b required 1", parity_err); end
    repeat (3) tick();
    n_checks++; if (parity_err !== 1'b1) begin n_fail++; $display("FAIL par_sticky: got %b required 1", parity_err); end
    n_checks++; if (cfg_bits !== model_cfg) begin n_fail++; $display("FAIL par_cfg: got %h required %h", cfg_bits, model_cfg); end
    val = CFG'($urandom);
    send_frame(beats_for(val), CL, 1, -1);
    n_checks++; if (config_done !== 1'b1) begin n_fail++; $display("FAIL par_good_done: got %b required 1", config_done); end
    model_cfg = val;
    config_enable = 1'b0;
    tick();
    n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL par_clear: got %b required 0", parity_err); end
    n_checks++; if (cfg_bits !== model_cfg) begin n_fail++; $display("FAIL par_good_cfg: got %h required %h", cfg_bits, model_cfg); end
  endtask
`endif

  task automatic test_reset_mid_frame();
    config_enable = 1'b1;
    send_frame(8'hFF, 2, 0, -1);
    pReset_n = 1'b0;
    #1;
    n_checks++; if (cfg_bits !== '0 || ccff_tail !== '0) begin
      n_fail++; $display("FAIL midrst_data: cfg=%h tail=%b required 0 0", cfg_bits, ccff_tail); end
    n_checks++; if (ccff_ready !== 1'b0 || config_done !== 1'b0 || cfg_abort !== 1'b0) begin
      n_fail++; $display("FAIL midrst_ctrl: ready=%b done=%b abort=%b required 0", ccff_ready, config_done, cfg_abort); end
    model_cfg = '0;
    config_enable = 1'b0;
    tick();
    pReset_n = 1'b1;
    tick();
    n_checks++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL midrst_state: got %0d required IDLE", dut.state_q); end
  endtask

  initial begin
    test_reset();
    test_load(0, "cont");
    test_load(3, "gap");
    test_abort();
    test_load(0, "reload");
    test_readback(-1);
    test_random();
`ifdef CCFF_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
